// File: rtl/col_output_ctrl.sv
// Collects per-column array results into a row buffer and, once every column
// has landed, pushes the row as WPR packed words into a show-ahead FIFO.
module col_output_ctrl #(
  parameter int COLS  = 8,
  parameter int DW    = 8,
  parameter int OW    = 32,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_r [0:COLS-1],
  input  logic          in_v [0:COLS-1],
  input  logic          rread,
  output logic [OW-1:0] out_r,
  output logic          rvalid
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int BPW = OW / DW;
  localparam int WPR = (COLS * DW) / OW;

  logic [DW-1:0] r_slot [0:COLS-1];
  logic [COLS-1:0] r_flag;
  logic [OW-1:0] r_mem [0:DEPTH-1];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic [OW-1:0] r_out;

  logic [DW-1:0] w_slot_nx [0:COLS-1];
  logic [COLS-1:0] w_flag_nx;
  logic [OW-1:0] w_word [0:WPR-1];
  logic          w_pend;
  logic          w_row_done;
  logic          w_pop;
  logic [CW:0]   w_free;
  logic          w_push;
  logic [CW-1:0] w_count_nx;
  logic [PW-1:0] w_rd_nx;
  logic [OW-1:0] w_head_nx;

  // A held row keeps every flag set, so "all flags set" at the start of a
  // cycle is exactly the pending condition; inputs are dropped while it holds.
  assign w_pend = &r_flag;

  always_comb begin
    w_slot_nx = r_slot;
    w_flag_nx = r_flag;
    if (!w_pend) begin
      for (int k = 0; k < COLS; k++) begin
        if (in_v[k]) begin
          w_slot_nx[k] = in_r[k];
          w_flag_nx[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int w = 0; w < WPR; w++) begin
      w_word[w] = '0;
      for (int b = 0; b < BPW; b++) begin
        w_word[w][b*DW +: DW] = w_slot_nx[w*BPW + b];
      end
    end
  end

  assign w_row_done = &w_flag_nx;
  assign w_pop      = rread && (r_count != '0);
  assign w_free     = (CW+1)'(DEPTH) - {1'b0, r_count} + (CW+1)'(w_pop);
  assign w_push     = w_row_done && (w_free >= (CW+1)'(WPR));
  assign w_count_nx = r_count + (w_push ? CW'(WPR) : '0) - CW'(w_pop);
  assign w_rd_nx    = r_rd + PW'(w_pop);

  // Register the next head so out_r is a clean flop; a freshly pushed word
  // may become the head on the same edge it is written.
  always_comb begin
    w_head_nx = r_out;
    if (w_count_nx != '0) begin
      w_head_nx = r_mem[w_rd_nx];
      if (w_push) begin
        for (int w = 0; w < WPR; w++) begin
          if (w_rd_nx == r_wr + PW'(w)) w_head_nx = w_word[w];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    r_slot <= w_slot_nx;
    if (w_push) begin
      for (int w = 0; w < WPR; w++) begin
        r_mem[r_wr + PW'(w)] <= w_word[w];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag  <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_out   <= '0;
    end else begin
      r_flag  <= w_push ? '0 : w_flag_nx;
      r_wr    <= w_push ? r_wr + PW'(WPR) : r_wr;
      r_rd    <= w_rd_nx;
      r_count <= w_count_nx;
      r_out   <= w_head_nx;
    end
  end

  assign out_r  = r_out;
  assign rvalid = (r_count != '0);

endmodule

// File: tb/tb_col_output_ctrl.sv
// Directed bench for col_output_ctrl: row capture, packing, FIFO full/pending,
// reset discard and concurrent push/pop ordering.
module tb_col_output_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  in_r [0:7];
  logic        in_v [0:7];
  logic        rread;
  logic [31:0] out_r;
  logic        rvalid;

  int n_cmp;
  int n_err;

  col_output_ctrl #(.COLS(8), .DW(8), .OW(32), .DEPTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .in_r  (in_r),
    .in_v  (in_v),
    .rread (rread),
    .out_r (out_r),
    .rvalid(rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] colval(input int r, input int k);
    return 8'(r * 16 + k);
  endfunction

  function automatic logic [31:0] rowword(input int r, input int w);
    logic [31:0] v;
    for (int b = 0; b < 4; b++) v[b*8 +: 8] = colval(r, w*4 + b);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_v();
    for (int k = 0; k < 8; k++) in_v[k] = 1'b0;
  endtask

  task automatic load_row(input int r);
    for (int k = 0; k < 8; k++) begin
      in_r[k] = colval(r, k);
      in_v[k] = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    rread = 1'b0;
    for (int k = 0; k < 8; k++) in_r[k] = 8'(k + 1);
    clr_v();
    tick();
    tick();
    check("reset_rvalid", 32'(rvalid), 32'd0);
    check("reset_out_r", out_r, 32'h0);
    rst = 1'b0;

    // walking one-hot capture
    for (int k = 0; k < 8; k++) begin
      clr_v();
      in_v[k] = 1'b1;
      tick();
      if (k < 7) check("walk_rvalid_early", 32'(rvalid), 32'd0);
    end
    clr_v();
    check("walk_rvalid", 32'(rvalid), 32'd1);
    check("walk_w0", out_r, 32'h04030201);
    rread = 1'b1;
    tick();
    check("walk_w1_valid", 32'(rvalid), 32'd1);
    check("walk_w1", out_r, 32'h08070605);
    tick();
    check("walk_empty", 32'(rvalid), 32'd0);
    tick();
    check("walk_underflow", 32'(rvalid), 32'd0);
    rread = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("walk_no_more", 32'(rvalid), 32'd0);

    // full row in one cycle
    for (int k = 0; k < 8; k++) begin
      in_r[k] = 8'(8'h11 * (k + 1));
      in_v[k] = 1'b1;
    end
    tick();
    clr_v();
    check("full_rvalid", 32'(rvalid), 32'd1);
    check("full_w0", out_r, 32'h44332211);
    rread = 1'b1;
    tick();
    check("full_w1", out_r, 32'h88776655);
    tick();
    check("full_empty", 32'(rvalid), 32'd0);
    rread = 1'b0;

    // overwrite of column 2 before completion
    in_v[2] = 1'b1;
    in_r[2] = 8'hAA;
    tick();
    in_r[2] = 8'hBB;
    tick();
    check("ovw_not_done", 32'(rvalid), 32'd0);
    clr_v();
    for (int k = 0; k < 8; k++) begin
      if (k != 2) begin
        in_r[k] = 8'(8'h11 * (k + 1));
        in_v[k] = 1'b1;
      end
    end
    tick();
    clr_v();
    check("ovw_w0", out_r, 32'h44BB2211);
    rread = 1'b1;
    tick();
    check("ovw_w1", out_r, 32'h88776655);
    tick();
    check("ovw_empty", 32'(rvalid), 32'd0);
    rread = 1'b0;

    // fill FIFO with 4 rows, then a held 5th row and a dropped 6th
    for (int r = 1; r <= 4; r++) begin
      load_row(r);
      tick();
    end
    clr_v();
    check("fill_rvalid", 32'(rvalid), 32'd1);
    check("fill_head", out_r, rowword(1, 0));
    load_row(5);
    tick();
    load_row(6);
    tick();
    clr_v();
    check("fill_head_held", out_r, rowword(1, 0));
    rread = 1'b1;
    for (int i = 1; i < 10; i++) begin
      tick();
      check("fill_drain_valid", 32'(rvalid), 32'd1);
      check("fill_drain", out_r, rowword(i / 2 + 1, i % 2));
    end
    tick();
    check("fill_empty", 32'(rvalid), 32'd0);
    rread = 1'b0;

    // reset with a non-empty FIFO
    load_row(7);
    tick();
    clr_v();
    check("rstq_pre", 32'(rvalid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstq_rvalid", 32'(rvalid), 32'd0);
    check("rstq_out_r", out_r, 32'h0);

    // reset mid-row discards columns 0..4
    for (int k = 0; k < 5; k++) in_v[k] = 1'b1;
    tick();
    clr_v();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 5; k < 8; k++) in_v[k] = 1'b1;
    tick();
    clr_v();
    check("rstrow_rvalid", 32'(rvalid), 32'd0);
    tick();
    check("rstrow_rvalid2", 32'(rvalid), 32'd0);
    // the missing columns then complete the row that restarted after reset
    for (int k = 0; k < 5; k++) begin
      in_r[k] = colval(8, k);
      in_v[k] = 1'b1;
    end
    for (int k = 5; k < 8; k++) in_r[k] = colval(8, k);
    tick();
    clr_v();
    check("rstrow_after", 32'(rvalid), 32'd1);
    check("rstrow_w0", out_r, rowword(8, 0));
    rread = 1'b1;
    tick();
    tick();
    check("rstrow_drained", 32'(rvalid), 32'd0);

    // concurrent push and pop with rread held high
    for (int n = 1; n <= 8; n++) begin
      if (n <= 4) load_row(n);
      else clr_v();
      tick();
      check("pp_valid", 32'(rvalid), 32'd1);
      check("pp_word", out_r, rowword((n - 1) / 2 + 1, (n - 1) % 2));
    end
    clr_v();
    tick();
    check("pp_empty", 32'(rvalid), 32'd0);
    rread = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/col_output_ctrl.md
# col_output_ctrl

Output collector for one edge of the systolic array. It captures 8-bit results arriving from eight array columns, each with its own valid strobe, into a row buffer. When all eight columns of a row have been captured, it packs the row into two 32-bit words and pushes them into a show-ahead output FIFO. The host drains the FIFO through a simple valid/read port.

## Interface
- COLS, 8, number of array columns (fixed; must equal 8 in this revision)
- DW, 8, bits per column result
- OW, 32, output word width (COLS*DW must be a multiple of OW; 2 words per row)
- DEPTH, 8, output FIFO depth in OW-bit words (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  one clock; reset is synchronous and active-high
- in_r  in  COLS×DW (unpacked array [0:COLS-1] of DW bits)  per-column result data
- in_v  in  COLS (unpacked array [0:COLS-1] of 1 bit)  per-column data valid
- rread  in  1  pop request; honoured only when rvalid=1
- out_r  out  OW  head-of-FIFO word (show-ahead)
- rvalid  out  1  FIFO non-empty

## Operation
- Row buffer: COLS DW-bit slots plus COLS captured flags.
- At a rising edge, each column k with in_v[k]=1 writes in_r[k] into slot k and sets flag k.
- Columns may arrive in any order, over any number of cycles, and several columns may arrive in the same cycle.
- Re-valid of an already-flagged column before the row completes overwrites slot k. The flag stays set.
- Row completion: at an edge where every flag is set, counting columns captured that same edge, the row is complete.
- On completion with ≥2 free FIFO entries:
  - Word 0 (slots 0–3, slot 0 in bits 7:0, slot 3 in bits 31:24) is written first.
  - Word 1 (slots 4–7, same byte ordering) is written after it.
  - Both writes happen on the same edge.
  - All flags clear on that edge.
- On completion with <2 free entries, the row is held and marked pending:
  - While pending, all in_v are ignored and that data is lost.
  - The row is pushed on the first edge where 2 entries are free, including space freed by a pop on that same edge.
- FIFO read:
  - out_r always shows the oldest word.
  - rvalid = (count != 0).
  - rread=1 with rvalid=1 pops one word at the edge.
  - rread with rvalid=0 is ignored and causes no underflow.
- Simultaneous push (2 words) and pop (1 word): net count +1. Pointers wrap modulo DEPTH.
- out_r when empty: holds the last value presented. It is don't-care to the consumer; the implementation holds it.

## Timing
- Reset (rst=1 at an edge):
  - Flags, pending state, FIFO pointers and count are cleared.
  - rvalid=0 and out_r=0 after that edge.
  - in_v and rread are ignored during reset.
  - Reset mid-row discards the partial row. Reset with a non-empty FIFO discards all words.
- Capture latency: data on in_r/in_v at edge t is in the row buffer after t.
- Completion to output latency: the edge completing the row (t) also writes the FIFO. rvalid=1 and out_r=word 0 are visible right after t.
- Pop latency: rread at edge t makes the next word (or rvalid=0) visible after t.
- Throughput: up to one complete row per cycle into the FIFO; one word per cycle out.

## Test plan
- Walking one-hot: in_r[k]=k+1, in_v one-hot on column 0..7 over cycles 0..7, then zero for 8 cycles; rread driven from rvalid → rvalid rises after the 8th capture, out_r=0x04030201, then 0x08070605, then rvalid=0; no further words.
- Full row in one cycle: all in_v=1 with in_r=0x11..0x88 for one cycle → two words 0x44332211, 0x88776655 available the next cycle.
- Overwrite: column 2 valid with 0xAA then 0xBB before the row completes → word 0 byte 2 = 0xBB.
- FIFO full: DEPTH=8, complete 4 rows without reading → rvalid=1, count 8. A 5th row is held (further in_v ignored); after 2 pops it is pushed. Order of all words is preserved.
- Reset mid-operation: capture columns 0–4, assert rst for one cycle, then complete columns 5–7 only → no word produced; rvalid stays 0.
- Simultaneous push/pop: rread held high while rows complete every cycle → words emerge in order, no loss, no duplication.
